// File: rtl/fifo_pkg.sv
// Package: fifo_pkg
// Build configuration, counter types and the keep-mask helper shared by
// fifo_rd_packer and its optional flush timer. The module parameters of
// fifo_rd_packer default to these values and must agree with them.
package fifo_pkg;

    localparam int PKG_WIDTH        = 8;
    localparam int PKG_RATIO        = 4;
    localparam int PKG_FLUSH_CYCLES = 16;

    // Lane count runs 0..RATIO inclusive, so one extra code is needed.
    typedef logic [$clog2(PKG_RATIO+1)-1:0]        lane_cnt_t;
    // Idle counter saturates at FLUSH_CYCLES.
    typedef logic [$clog2(PKG_FLUSH_CYCLES+1)-1:0] idle_cnt_t;
    typedef logic [PKG_RATIO-1:0]                  keep_t;

    // Low cnt bits set: lanes 0..cnt-1 hold valid words.
    function automatic keep_t mask_from_count(input lane_cnt_t cnt);
        keep_t m;
        m = '0;
        for (int i = 0; i < PKG_RATIO; i++) begin
            m[i] = (lane_cnt_t'(i) < cnt);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_flush_timer.sv
// Module: pack_flush_timer
// Counts idle cycles while a partial beat sits in the pack register with
// nothing in flight and the FIFO empty, and requests a flush of that partial
// beat once FLUSH_CYCLES such cycles have elapsed. Only instantiated when
// PACK_FLUSH_EN is defined.
module pack_flush_timer
    import fifo_pkg::*;
#(
    parameter int FLUSH_CYCLES = PKG_FLUSH_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic partial,    // 0 < cnt < RATIO
    input  logic pend,       // a popped word arrives this cycle
    input  logic rempty,
    input  logic pop,        // a pop is accepted this cycle
    input  logic fire,       // the partial beat transfers this cycle
    output logic flush_req
);

    localparam idle_cnt_t IDLE_MAX = idle_cnt_t'(FLUSH_CYCLES);

    idle_cnt_t idle_q, idle_d;

    // Next idle count: restart on any pop, flush or non-partial state, saturate at the limit.
    always_comb begin
        idle_d = idle_q;
        if (pop || fire || !partial) begin
            idle_d = '0;
        end else if (!pend && rempty && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + idle_cnt_t'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    // Request stays up until the output register is free to take the beat.
    assign flush_req = partial && !pend && (idle_q == IDLE_MAX);

endmodule

// File: rtl/fifo_rd_packer.sv
// Module: fifo_rd_packer
// Read-side consumer of asyn_fifo (rclk domain). Pops WIDTH-bit words and
// packs RATIO consecutive words, first word in lane 0, into one beat that is
// presented on a valid/ready stream. One beat can wait in the output register
// while the next one is being packed.
// Optional feature macro PACK_FLUSH_EN: flushes a partial beat (with m_keep
// marking the filled lanes) after FLUSH_CYCLES idle cycles. Without it,
// partial beats wait until filled and m_keep is constant all-ones.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH        = PKG_WIDTH,
    parameter int RATIO        = PKG_RATIO,
    parameter int FLUSH_CYCLES = PKG_FLUSH_CYCLES
) (
    input  logic                     rclk,
    input  logic                     rrstn,
    input  logic                     rempty,
    output logic                     rinc,
    input  logic [WIDTH-1:0]         rdata,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH*RATIO-1:0]   m_data,
    output logic [RATIO-1:0]         m_keep
);

    localparam int        BEAT_W = WIDTH * RATIO;
    localparam int        CNT_W  = $bits(lane_cnt_t);
    localparam lane_cnt_t FULL   = lane_cnt_t'(RATIO);

    lane_cnt_t          cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [BEAT_W-1:0]  pack_q, pack_d;
    logic [BEAT_W-1:0]  m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;

    logic               out_free;
    logic               xfer_full;
    logic               xfer_flush;
    logic               xfer;
    keep_t              beat_keep;
    lane_cnt_t          base_cnt;
    logic [CNT_W:0]     fill;

    assign out_free  = !m_valid_q || m_ready;
    assign xfer_full = (cnt_q == FULL) && out_free;

`ifdef PACK_FLUSH_EN
    logic  flush_req;
    logic  partial;
    logic  pop;
    keep_t m_keep_q, m_keep_d;

    assign partial    = (cnt_q != '0) && (cnt_q != FULL);
    assign pop        = rinc;
    assign xfer_flush = flush_req && out_free;
    assign beat_keep  = xfer_flush ? mask_from_count(cnt_q) : '1;

    pack_flush_timer #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk       (rclk),
        .rst_n     (rrstn),
        .partial   (partial),
        .pend      (pend_q),
        .rempty    (rempty),
        .pop       (pop),
        .fire      (xfer_flush),
        .flush_req (flush_req)
    );

    // Keep mask is captured together with the beat it describes.
    always_comb begin
        m_keep_d = m_keep_q;
        if (xfer) begin
            m_keep_d = beat_keep;
        end
    end

    // Keep mask register; all lanes valid out of reset.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            m_keep_q <= '1;
        end else begin
            m_keep_q <= m_keep_d;
        end
    end

    assign m_keep = m_keep_q;
`else
    logic unused_flush_cfg;

    assign xfer_flush       = 1'b0;
    assign beat_keep        = '1;
    assign m_keep           = '1;
    assign unused_flush_cfg = (FLUSH_CYCLES < 1);
`endif

    assign xfer = xfer_full || xfer_flush;

    // Pop request: room must remain for every word already packed or in flight.
    // A transfer in this cycle frees the whole pack register, so it counts as empty.
    always_comb begin
        base_cnt = xfer ? '0 : cnt_q;
        fill     = {1'b0, base_cnt} + {{CNT_W{1'b0}}, pend_q};
        rinc     = !rempty && (fill < (CNT_W+1)'(RATIO));
    end

    // Lane count and in-flight flag; an arriving word never coincides with a transfer.
    always_comb begin
        pend_d = rinc;
        cnt_d  = (xfer ? '0 : cnt_q) + lane_cnt_t'(pend_q);
    end

    // Arriving word lands in the lane selected by the current count.
    always_comb begin
        pack_d = pack_q;
        for (int i = 0; i < RATIO; i++) begin
            if (pend_q && (cnt_q == lane_cnt_t'(i))) begin
                pack_d[i*WIDTH +: WIDTH] = rdata;
            end
        end
    end

    // Output register: load on transfer, drop valid on accept, otherwise hold.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (xfer) begin
            m_valid_d = 1'b1;
            for (int i = 0; i < RATIO; i++) begin
                m_data_d[i*WIDTH +: WIDTH] = beat_keep[i] ? pack_q[i*WIDTH +: WIDTH] : '0;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Control and output registers; reset discards any partial beat, pending pop and held beat.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Pack register holds data only; stale lanes are never exposed.
    always_ff @(posedge rclk) begin
        pack_q <= pack_d;
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: models the asyn_fifo read port with a queue,
// drives directed and random stimulus, and checks every accepted beat against
// the sequence of words pushed into the FIFO.
module tb_fifo_rd_packer;

    localparam int WIDTH  = 8;
    localparam int RATIO  = 4;
    localparam int BEAT_W = WIDTH * RATIO;

    logic              rclk = 1'b0;
    logic              rrstn;
    logic              rempty;
    logic              rinc;
    logic [WIDTH-1:0]  rdata;
    logic              m_valid;
    logic              m_ready;
    logic [BEAT_W-1:0] m_data;
    logic [RATIO-1:0]  m_keep;

    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int rinc_viol = 0;

    logic [WIDTH-1:0] fifo_q[$];   // words still inside the FIFO
    logic [WIDTH-1:0] exp_q[$];    // words not yet seen in an accepted beat

    fifo_rd_packer #(
        .WIDTH        (WIDTH),
        .RATIO        (RATIO),
        .FLUSH_CYCLES (16)
    ) dut (
        .rclk    (rclk),
        .rrstn   (rrstn),
        .rempty  (rempty),
        .rinc    (rinc),
        .rdata   (rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // Next beat = next RATIO pushed words, lane 0 first; a shorter tail is a flushed partial beat.
    task automatic check_beat();
        logic [BEAT_W-1:0] d;
        logic [RATIO-1:0]  k;
        int n;
        n = (exp_q.size() >= RATIO) ? RATIO : exp_q.size();
        d = '0;
        k = '0;
        for (int i = 0; i < n; i++) begin
            d[i*WIDTH +: WIDTH] = exp_q.pop_front();
            k[i] = 1'b1;
        end
        chk("beat_data", m_data, d);
        chk("beat_keep", m_keep, k);
        beats_seen++;
    endtask

    // One clock: drive at posedge+1, observe at negedge, FIFO read data appears after the edge.
    task automatic do_cycle(input bit rdy, input bit force_empty);
        bit pop;
        m_ready = rdy;
        rempty  = force_empty || (fifo_q.size() == 0);
        @(negedge rclk);
        if (rinc && rempty) rinc_viol++;
        pop = rinc && !rempty;
        if (m_valid && m_ready) check_beat();
        @(posedge rclk);
        #1;
        if (pop && (fifo_q.size() > 0)) rdata = fifo_q.pop_front();
    endtask

    // mode 0: ready high, FIFO as-is; 1: rempty forced every other cycle; 2: random.
    task automatic run(input int target, input int max_cycles, input int mode);
        int n;
        n = 0;
        while ((beats_seen < target) && (n < max_cycles)) begin
            case (mode)
                0:       do_cycle(1'b1, 1'b0);
                1:       do_cycle(1'b1, (n % 2) == 1);
                default: do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            endcase
            n++;
        end
    endtask

    initial begin
        logic [BEAT_W-1:0] hold;

        rrstn   = 1'b0;
        rempty  = 1'b1;
        m_ready = 1'b0;
        rdata   = '0;
        repeat (3) @(posedge rclk);
        #1;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data",  m_data, 32'h0);
        chk("rst_keep",  m_keep, 4'hF);
        chk("rst_rinc",  rinc, 1'b0);
        @(negedge rclk);
        rrstn = 1'b1;
        @(posedge rclk);
        #1;

        // Streaming with m_ready high.
        for (int i = 1; i <= 8; i++) push(WIDTH'(i));
        beats_seen = 0;
        run(2, 100, 0);
        chk("stream_beats", beats_seen, 2);

        // Backpressure: one beat held in the output plus a full pack register.
        for (int i = 0; i < 12; i++) push(WIDTH'(8'h10 + i));
        beats_seen = 0;
        repeat (20) do_cycle(1'b0, 1'b0);
        chk("bp_valid", m_valid, 1'b1);
        chk("bp_rinc", rinc, 1'b0);
        chk("bp_fifo_left", fifo_q.size(), 4);
        hold = m_data;
        repeat (5) do_cycle(1'b0, 1'b0);
        chk("bp_hold", m_data, hold);
        chk("bp_data", m_data, 32'h13121110);
        run(3, 100, 0);
        chk("bp_beats", beats_seen, 3);
        chk("bp_drained", exp_q.size(), 0);

        // rempty toggling mid-beat.
        for (int i = 0; i < 8; i++) push(WIDTH'(8'h21 + i));
        beats_seen = 0;
        run(2, 200, 1);
        chk("toggle_beats", beats_seen, 2);

        // Reset with one beat waiting and two words packed.
        for (int i = 0; i < 6; i++) push(WIDTH'(8'h31 + i));
        repeat (12) do_cycle(1'b0, 1'b0);
        chk("pre_rst_valid", m_valid, 1'b1);
        chk("pre_rst_fifo", fifo_q.size(), 0);
        @(negedge rclk);
        rrstn = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_data", m_data, 32'h0);
        chk("mid_rst_keep", m_keep, 4'hF);
        exp_q.delete();
        fifo_q.delete();
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrstn = 1'b1;
        @(posedge rclk);
        #1;
        for (int i = 0; i < 4; i++) push(WIDTH'(8'h41 + i));
        beats_seen = 0;
        run(1, 50, 0);
        chk("post_rst_beats", beats_seen, 1);

        // Random ready/empty over 10k words.
        for (int i = 0; i < 10000; i++) push(WIDTH'($urandom_range(0, 255)));
        beats_seen = 0;
        run(2500, 60000, 2);
        chk("rand_beats", beats_seen, 2500);
        chk("rand_left", exp_q.size(), 0);

        // Two words, then idle.
        push(8'hAA);
        push(8'hBB);
        beats_seen = 0;
        run(1, 60, 0);
`ifdef PACK_FLUSH_EN
        chk("flush_beats", beats_seen, 1);
`else
        chk("noflush_beats", beats_seen, 0);
        chk("noflush_valid", m_valid, 1'b0);
`endif

        chk("rinc_while_empty", rinc_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
